// File: rtl/spi_pkg.sv
// spi_pkg - shared types and constants for the mode-3 SPI debug-read master.
//   state_t      : frame sequencer states
//   FRAME_BITS   : SCLK periods per frame (address + data)
//   ADDR_BITS    : register address width sent on mosi
//   DATA_BITS    : register value width returned on miso
//   ADDR_*       : debug slave register map
//   mosi_bit()   : address bit driven during a given SCLK period
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam int FRAME_BITS = 18;
  localparam int ADDR_BITS  = 2;
  localparam int DATA_BITS  = 16;

  localparam logic [ADDR_BITS-1:0] ADDR_REGD  = 2'd0;
  localparam logic [ADDR_BITS-1:0] ADDR_REGA  = 2'd1;
  localparam logic [ADDR_BITS-1:0] ADDR_PC    = 2'd2;
  localparam logic [ADDR_BITS-1:0] ADDR_STATE = 2'd3;

  // Periods 0 and 1 carry the address MSB first; data periods drive 0.
  function automatic logic mosi_bit(input logic [ADDR_BITS-1:0] addr,
                                    input logic [4:0]           idx);
    case (idx)
      5'd0:    return addr[1];
      5'd1:    return addr[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if - request/response and SPI pin bundle of spi_master.
//   start_i, addr_i : frame request and register address
//   busy_o, done_o  : frame in progress, one-cycle read-complete pulse
//   data_o          : last register value read
//   sclk_o, csb_o, mosi_o, miso_i : SPI pins toward the debug slave
// Modport master is the spi_master side; modport slave is its user/peer.
interface spi_master_if;
  import spi_pkg::*;

  logic                 start_i;
  logic [ADDR_BITS-1:0] addr_i;
  logic                 busy_o;
  logic                 done_o;
  logic [DATA_BITS-1:0] data_o;
  logic                 sclk_o;
  logic                 csb_o;
  logic                 mosi_o;
  logic                 miso_i;

  modport master (
    input  start_i, addr_i, miso_i,
    output busy_o, done_o, data_o, sclk_o, csb_o, mosi_o
  );

  modport slave (
    output start_i, addr_i, miso_i,
    input  busy_o, done_o, data_o, sclk_o, csb_o, mosi_o
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff - two-flop synchroniser, async active-low reset to 0.
//   clk_i  : destination clock
//   resetb : asynchronous active-low reset
//   d      : asynchronous input
//   q      : synchronised output (two clk_i cycles of latency)
module sync_2ff (
  input  logic clk_i,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk_i or negedge resetb) begin
    if (!resetb) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master - mode-3 SPI master reading 16-bit registers of the debug slave.
// Each frame is exactly 18 SCLK periods: 2 address bits out, 16 data bits in.
// Frames are never shortened, since the slave's bit counter free-runs.
//   clk_i  : system clock (rising edge)
//   resetb : asynchronous active-low reset, aborts any frame
//   bus    : spi_master_if.master (request, response and SPI pins)
// Parameter CLK_DIV: system clocks per SCLK half-period (>=1, >=3 with sync).
// Macro SPI_MASTER_MISO_SYNC_EN: route miso through sync_2ff before sampling.
//
// state | meaning
// IDLE  | csb high, sclk high, waiting for start_i
// SETUP | csb low, sclk high, CLK_DIV cycles before first fall
// LOW   | sclk low, mosi set on entry
// HIGH  | sclk high; miso sampled on entry
// HOLD  | last rise to csb release, mosi back to 0
// GAP   | csb high for CLK_DIV cycles; done_o on entry
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic          clk_i,
  input  logic          resetb,
  spi_master_if.master  bus
);

  localparam int                DIV_W          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LOAD       = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]        LAST_BIT       = 5'(FRAME_BITS - 1);
  localparam logic [4:0]        FIRST_DATA_BIT = 5'(ADDR_BITS);

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic [4:0]           bit_idx;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] rx_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 sclk_q;
  logic                 csb_q;
  logic                 mosi_q;
  logic                 miso_s;
  logic                 phase_end;

`ifdef SPI_MASTER_MISO_SYNC_EN
  sync_2ff u_miso_sync (
    .clk_i  (clk_i),
    .resetb (resetb),
    .d      (bus.miso_i),
    .q      (miso_s)
  );
`else
  assign miso_s = bus.miso_i;
`endif

  // Down-counter reloads at every phase boundary, so every phase is CLK_DIV long.
  assign phase_end = (div_cnt == '0);

  always_ff @(posedge clk_i or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      div_cnt <= DIV_LOAD;
      bit_idx <= '0;
      addr_q  <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b1;
      csb_q   <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE || phase_end) div_cnt <= DIV_LOAD;
      else                            div_cnt <= div_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (bus.start_i) begin
            state   <= SETUP;
            addr_q  <= bus.addr_i;
            bit_idx <= '0;
            busy_q  <= 1'b1;
            csb_q   <= 1'b0;
          end
        end
        SETUP: begin
          if (phase_end) begin
            state  <= LOW;
            sclk_q <= 1'b0;
            mosi_q <= mosi_bit(addr_q, bit_idx);
          end
        end
        LOW: begin
          if (phase_end) begin
            state  <= HIGH;
            sclk_q <= 1'b1;
            if (bit_idx >= FIRST_DATA_BIT) rx_q <= {rx_q[DATA_BITS-2:0], miso_s};
          end
        end
        HIGH: begin
          if (phase_end) begin
            if (bit_idx < LAST_BIT) begin
              state   <= LOW;
              sclk_q  <= 1'b0;
              bit_idx <= bit_idx + 5'd1;
              mosi_q  <= mosi_bit(addr_q, bit_idx + 5'd1);
            end else begin
              state  <= HOLD;
              mosi_q <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            state  <= GAP;
            csb_q  <= 1'b1;
            data_q <= rx_q;
            done_q <= 1'b1;
          end
        end
        GAP: begin
          if (phase_end) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.data_o = data_q;
  assign bus.sclk_o = sclk_q;
  assign bus.csb_o  = csb_q;
  assign bus.mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master - directed bench: two spi_master instances, each wired to a
// behavioural model of the mode-3 debug slave. Instance 0 runs CLK_DIV=4;
// instance 1 runs CLK_DIV=1 (direct miso) or CLK_DIV=3 (SPI_MASTER_MISO_SYNC_EN).
module tb_spi_master;
  import spi_pkg::*;

  localparam int CLK_DIV_MAIN = 4;
`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam int CLK_DIV_ALT = 3;
`else
  localparam int CLK_DIV_ALT = 1;
`endif

  logic clk;
  logic resetb;

  logic [1:0]       start;
  logic [1:0][1:0]  addr_v;
  logic [1:0]       busy_v, done_v, sclk_v, csb_v, mosi_v;
  logic [1:0][15:0] data_v;
  logic [1:0][15:0] falls_v, extra_v, lows_v, perr_v;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] reg_val(input logic [1:0] a);
    case (a)
      ADDR_REGD:  return 16'hA5C3;
      ADDR_REGA:  return 16'h1234;
      ADDR_PC:    return 16'h00FF;
      default:    return {14'd0, 2'b10};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D = (g == 0) ? CLK_DIV_MAIN : CLK_DIV_ALT;

    spi_master_if bus ();

    spi_master #(.CLK_DIV(D)) u_dut (
      .clk_i  (clk),
      .resetb (resetb),
      .bus    (bus.master)
    );

    assign bus.start_i = start[g];
    assign bus.addr_i  = addr_v[g];
    assign busy_v[g]   = bus.busy_o;
    assign done_v[g]   = bus.done_o;
    assign data_v[g]   = bus.data_o;
    assign sclk_v[g]   = bus.sclk_o;
    assign csb_v[g]    = bus.csb_o;
    assign mosi_v[g]   = bus.mosi_o;

    // Debug slave: samples si on rise, drives so on fall, free-running 18-bit count.
    logic [4:0] s_cnt;
    logic [1:0] s_addr;
    logic       so;
    assign bus.miso_i = so;

    always @(posedge bus.sclk_o or negedge resetb) begin
      if (!resetb) begin
        s_cnt  <= 5'd0;
        s_addr <= 2'd0;
      end else if (!bus.csb_o) begin
        if (s_cnt < 5'd2) s_addr <= {s_addr[0], bus.mosi_o};
        s_cnt <= (s_cnt == 5'd17) ? 5'd0 : s_cnt + 5'd1;
      end
    end

    always @(negedge bus.sclk_o or negedge resetb) begin : slave_tx
      logic [15:0] v;
      if (!resetb) begin
        so <= 1'b0;
      end else if (!bus.csb_o && s_cnt >= 5'd2) begin
        v  = reg_val(s_addr);
        so <= v[4'(5'd17 - s_cnt)];
      end
    end

    // Pin monitor: falls inside/outside csb, and phase-width errors.
    int   fall_cnt = 0;
    int   extra    = 0;
    int   lows     = 0;
    int   perr     = 0;
    int   run      = 0;
    logic prev     = 1'b1;
    bit   seen_low = 1'b0;

    always @(negedge bus.sclk_o) begin
      if (!bus.csb_o) fall_cnt++;
      else            extra++;
    end

    always @(negedge clk) begin
      if (bus.sclk_o != prev) begin
        if (!prev) begin
          lows++;
          if (run != D) perr++;
        end else if (seen_low && run != D) begin
          perr++;
        end
        if (!bus.sclk_o) seen_low = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      if (bus.csb_o) seen_low = 1'b0;
      prev = bus.sclk_o;
    end

    assign falls_v[g] = fall_cnt[15:0];
    assign extra_v[g] = extra[15:0];
    assign lows_v[g]  = lows[15:0];
    assign perr_v[g]  = perr[15:0];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int div_of(input int g);
    return (g == 0) ? CLK_DIV_MAIN : CLK_DIV_ALT;
  endfunction

  // Called on a negedge while the DUT is idle; returns on the first idle cycle.
  // keep: 0 drop start after acceptance, 1 hold it, 2 hold until done_o.
  task automatic run_frame(input int g, input logic [1:0] a, input int keep,
                           output int t_done, output int t_idle, output int done_w,
                           output int n_falls, output logic [15:0] d);
    int cyc;
    int f0;
    f0 = int'(falls_v[g]);
    start[g]  = 1'b1;
    addr_v[g] = a;
    @(negedge clk);
    cyc = 1;
    if (keep == 0) start[g] = 1'b0;
    t_done = -1;
    done_w = 0;
    while (busy_v[g] && cyc < 4000) begin
      if (done_v[g]) begin
        if (t_done < 0) t_done = cyc;
        done_w++;
        if (keep == 2) start[g] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    t_idle  = cyc;
    n_falls = int'(falls_v[g]) - f0;
    d       = data_v[g];
  endtask

  task automatic check_frame(input string tag, input int g, input logic [1:0] a,
                             input int keep, input logic [15:0] exp_data);
    int t_done, t_idle, done_w, n_falls;
    logic [15:0] d;
    run_frame(g, a, keep, t_done, t_idle, done_w, n_falls, d);
    check_val({tag, ".data"},   32'(d), 32'(exp_data));
    check_val({tag, ".t_done"}, t_done, 1 + 38 * div_of(g));
    check_val({tag, ".t_idle"}, t_idle, 1 + 39 * div_of(g));
    check_val({tag, ".done_w"}, done_w, 1);
    check_val({tag, ".falls"},  n_falls, 18);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cyc;
    int f0;
    int seen;

    resetb = 1'b0;
    start  = '0;
    addr_v = '0;
    repeat (3) @(negedge clk);
    check_val("rst.busy", 32'(busy_v[0]), 32'd0);
    check_val("rst.done", 32'(done_v[0]), 32'd0);
    check_val("rst.data", 32'(data_v[0]), 32'd0);
    check_val("rst.sclk", 32'(sclk_v[0]), 32'd1);
    check_val("rst.csb",  32'(csb_v[0]),  32'd1);
    check_val("rst.mosi", 32'(mosi_v[0]), 32'd0);
    resetb = 1'b1;
    repeat (2) @(negedge clk);

    check_frame("rd_regd", 0, ADDR_REGD, 0, 16'hA5C3);

    check_frame("b2b_rega",  0, ADDR_REGA,  1, 16'h1234);
    check_frame("b2b_pc",    0, ADDR_PC,    1, 16'h00FF);
    check_frame("b2b_state", 0, ADDR_STATE, 2, 16'h0002);
    check_val("b2b.extra_falls", 32'(extra_v[0]), 32'd0);

    fork
      check_frame("ign_regd", 0, ADDR_REGD, 0, 16'hA5C3);
      begin
        repeat (40) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 0;
        while (!done_v[0] && cyc < 400) begin
          @(negedge clk);
          cyc++;
        end
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
      end
    join
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy_v[0] || done_v[0]) seen++;
    end
    check_val("ign.no_extra_frame", seen, 0);
    check_val("ign.data_held", 32'(data_v[0]), 32'hA5C3);

    start[0]  = 1'b1;
    addr_v[0] = ADDR_STATE;
    @(negedge clk);
    start[0] = 1'b0;
    f0  = int'(falls_v[0]);
    cyc = 0;
    while ((int'(falls_v[0]) - f0) < 10 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    while (!sclk_v[0] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_val("rst_mid.reached_bit9", 32'(cyc < 2000), 32'd1);
    resetb = 1'b0;
    #1;
    check_val("rst_mid.csb",  32'(csb_v[0]),  32'd1);
    check_val("rst_mid.sclk", 32'(sclk_v[0]), 32'd1);
    check_val("rst_mid.busy", 32'(busy_v[0]), 32'd0);
    check_val("rst_mid.data", 32'(data_v[0]), 32'd0);
    @(negedge clk);
    resetb = 1'b1;
    repeat (2) @(negedge clk);
    check_frame("rst_pc", 0, ADDR_PC, 0, 16'h00FF);

    check_frame("alt_regd", 1, ADDR_REGD, 0, 16'hA5C3);
    check_val("alt.lows",        32'(lows_v[1]),  32'd18);
    check_val("alt.phase_err",   32'(perr_v[1]),  32'd0);
    check_val("alt.extra_falls", 32'(extra_v[1]), 32'd0);
    check_val("main.phase_err",  32'(perr_v[0]),  32'd0);
    check_val("main.extra_falls", 32'(extra_v[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Mode-3 SPI master that reads the CPU debug registers exposed by the on-chip SPI debug slave. Sits directly upstream of the slave in the debug path and generates sclk, chip select and serial address. Each frame carries a 2-bit register address and returns the 16-bit register value, so the debug port can be exercised end to end inside one clock domain (bench, FPGA self-test, on-chip monitor).

## Interface
- CLK_DIV, default 4: system clocks per SCLK half-period; legal ≥1, or ≥3 when SPI_MASTER_MISO_SYNC_EN is defined.
- clk_i  input  1  system clock; all logic is on its rising edge.
- resetb  input  1  asynchronous, active-low reset; outputs go to reset values immediately.
- start_i  input  1  request a frame; sampled only when busy_o=0.
- addr_i  input  2  register address, latched at start: 0 regD, 1 regA, 2 pc, 3 state.
- busy_o  output  1  frame in progress; reset 0.
- done_o  output  1  one-cycle pulse, data_o valid; reset 0.
- data_o  output  16  last read value, held until the next done_o; reset 16'h0000.
- sclk_o  output  1  SPI clock, idles high; reset 1.
- csb_o  output  1  chip select, active low; reset 1.
- mosi_o  output  1  serial address to slave si; reset 0.
- miso_i  input  1  serial data from slave so.

## Operation
- Frame is exactly 18 SCLK periods, MSB first: periods 0–1 carry addr[1], addr[0] on mosi_o; periods 2–17 return data[15]..data[0] on miso_i.
- The slave's bit counter is free-running across frames, so the master never aborts or shortens a frame. Any frame not exactly 18 periods desynchronises the slave until resetb.
- FSM states:
  - IDLE: csb_o=1, sclk_o=1. start_i=1 latches addr_i and goes to SETUP.
  - SETUP: csb_o=0, sclk_o=1, CLK_DIV cycles. Goes to LOW.
  - LOW: sclk_o=0, CLK_DIV cycles. mosi_o is set at entry: address bit for periods 0–1, else 0.
  - HIGH: sclk_o=1, CLK_DIV cycles. Goes to LOW while the bit index is below 17, else to HOLD.
  - HOLD: sclk_o=1, csb_o=0, CLK_DIV cycles.
  - GAP: csb_o=1, CLK_DIV cycles. Goes to IDLE.
- Sampling: miso (raw or synchronised) is sampled on the clk edge that drives sclk_o 0→1. Periods 0–1 are discarded; periods 2–17 are shifted into a 16-bit rx register.
- Bit index is 5 bits, 0..17, reset to 0 at start. Divider counter is 0..CLK_DIV-1.
- data_o is loaded from the rx register on the HOLD→GAP edge. done_o=1 for that single cycle.
- start_i while busy_o=1 is ignored, not queued. This includes the done_o cycle.
- mosi_o returns to 0 in HOLD.
- resetb mid-frame aborts the frame: csb_o=1, sclk_o=1, state IDLE. resetb is shared with the slave so both resynchronise.

## Timing
- Cycle 0: start_i accepted. busy_o=1 and csb_o=0 from cycle 1.
- First sclk_o fall at cycle 1+CLK_DIV.
- done_o at cycle 1+38·CLK_DIV. busy_o=0 at cycle 1+39·CLK_DIV.
- Back-to-back: a new start_i is accepted on the first IDLE cycle. Minimum frame pitch is 39·CLK_DIV+1 cycles.
- Every SCLK high and low phase is exactly CLK_DIV cycles; no jitter.
- CSB setup to first fall, last rise to CSB rise, and CSB high time are each ≥ CLK_DIV cycles.

## Configuration
- SPI_MASTER_MISO_SYNC_EN:
  - Defined: miso_i passes through a two-flop synchroniser before sampling. Use for an asynchronous or off-chip slave. CLK_DIV ≥3 is required so the synchronised value reflects the post-fall bit.
  - Undefined: miso_i is sampled directly. Same-domain use, CLK_DIV ≥1.
- Frame timing is identical in both cases.

## Structure
- Shared package spi_pkg:
  - state enum (IDLE, SETUP, LOW, HIGH, HOLD, GAP)
  - FRAME_BITS=18, ADDR_BITS=2, DATA_BITS=16
  - address constants ADDR_REGD=0, ADDR_REGA=1, ADDR_PC=2, ADDR_STATE=3
- One sub-module, sync_2ff: two-flop synchroniser with async active-low reset to 0. It is instantiated only under SPI_MASTER_MISO_SYNC_EN.

## Test plan
- Bench: master connected to the debug slave, regD=16'hA5C3, regA=16'h1234, pc=16'h00FF, state=2'b10, CLK_DIV=4.
- Read addr 0 → done_o at cycle 153 after start, data_o=16'hA5C3; exactly 18 sclk_o falls while csb_o=0.
- Reads of addr 1, 2, 3 back-to-back, start_i held high → 16'h1234, 16'h00FF, 16'h0002; each done_o is one cycle wide with no extra SCLK edges between frames.
- start_i pulsed mid-frame and on the done_o cycle → ignored; frame count and data unchanged.
- resetb low at bit 9 of a frame → csb_o=1, sclk_o=1, busy_o=0, data_o=0 immediately; after release, a read of addr 2 returns 16'h00FF.
- CLK_DIV=1 without the macro, and CLK_DIV=3 with SPI_MASTER_MISO_SYNC_EN → addr 0 returns 16'hA5C3. Phase widths are exactly CLK_DIV cycles; busy_o span is 39·CLK_DIV cycles.
